tron_mem_arbiter: RTL
=====================

Name: tron_mem_arbiter

Overview:
- Shares the single-port synchronous data memory of the Tron 16-bit CPU between two requesters: the CPU load/store path and an I/O port (e.g. display or external DMA).
- Arbitration is fixed priority to the CPU, with an anti-starvation counter that forces an I/O grant after a bounded run of CPU grants.
- Sits between the Tron datapath/controller and the block RAM. It also returns read data with correct per-requester tagging.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 16, memory data width
MAX_BURST, 4, maximum consecutive CPU grants while io_req is waiting (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_gnt
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_WIDTH  CPU address
cpu_wdata  input  DATA_WIDTH  CPU write data
cpu_gnt  output  1  CPU access issued this cycle (combinational)
cpu_rvalid  output  1  CPU read data valid (registered)
cpu_rdata  output  DATA_WIDTH  CPU read data
io_req, io_we, io_addr, io_wdata  input  1/1/ADDR_WIDTH/DATA_WIDTH  I/O side, same rules as CPU
io_gnt  output  1  I/O access issued this cycle
io_rvalid  output  1  I/O read data valid
io_rdata  output  DATA_WIDTH  I/O read data
mem_addr  output  ADDR_WIDTH  memory address
mem_we  output  1  memory write enable
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after address

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: all gnt/rvalid = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - State: owner state = OWN_CPU, starve counter = 0, read-pending pipeline cleared.
  - Gnt and mem_we are forced 0 for the whole time reset is low.
- Owner FSM, two states, both out of reset:
  - OWN_CPU: last grant went to the CPU, or no grant has happened yet.
  - OWN_IO: last grant went to I/O.
  - The state only records history; the grant decision each cycle is combinational from the current req lines and the counter.
- Grant rule, evaluated every cycle:
  - starve = (cnt == MAX_BURST) && io_req.
  - cpu_gnt = cpu_req && !starve.
  - io_gnt = io_req && (!cpu_req || starve).
  - At most one gnt is high in any cycle.
- Counter update on the rising edge:
  - cpu_gnt && io_req: cnt <= cnt+1, saturating at MAX_BURST.
  - io_gnt, or !io_req: cnt <= 0.
  - Otherwise cnt holds.
- State update on the rising edge: OWN_CPU on cpu_gnt, OWN_IO on io_gnt, unchanged when neither is granted.
- Memory mux:
  - The granted requester's addr/we/wdata drive mem_* in the same cycle.
  - With no grant: mem_we = 0, and mem_addr/mem_wdata hold their last driven values.
- Write access: completes in the gnt cycle. No rvalid follows.
- Read access:
  - A granted read sets a registered tag (requester id, valid).
  - In the next cycle, the matching X_rvalid = 1 and X_rdata = mem_rdata, registered on that edge.
  - Fixed read latency is 1 cycle after gnt.
  - rdata holds its value until the next rvalid for that requester.
- Back-to-back: a new grant is allowed in the same cycle a prior read's rvalid is asserted. Throughput is one access per cycle.
- Requester contract:
  - After gnt, the requester may drop req or present a new request in the following cycle.
  - A req dropped before gnt is withdrawn without side effects.
- Reset mid-read: a pending rvalid is discarded. No rvalid may appear after reset deasserts until a new read is granted.
- MAX_BURST=1: while both requesters are continuously requesting, grants alternate CPU, IO, CPU, IO.

Test Plan:
1. Reset release, only cpu_req=1, cpu_we=1, addr=0x0010, wdata=0x0005:
   - Response: cpu_gnt=1 same cycle, mem_we=1, mem_addr=0x0010.
   - Next cycle: CPU read of 0x0010 gives cpu_rvalid=1 one cycle after gnt with cpu_rdata=0x0005, and io_rvalid stays 0.
2. cpu_req and io_req both held high continuously, MAX_BURST=4:
   - Response: grant pattern CPU,CPU,CPU,CPU,IO repeating.
   - Counter returns to 0 after each IO grant.
3. Only io_req=1, read addr=0x0003 preloaded with 0xBEEF:
   - Response: io_gnt=1 immediately, io_rvalid=1 and io_rdata=0xBEEF next cycle.
   - cpu_gnt remains 0 throughout.
4. Back-to-back CPU read 0x0001, then IO read 0x0002, in consecutive cycles (CPU drops req after its gnt):
   - Response: cpu_rvalid in cycle 2, io_rvalid in cycle 3.
   - Each carries its own address's data, with no cross-tagging.
5. Assert reset low in the cycle after a granted CPU read:
   - Response: cpu_rvalid never pulses, all outputs read 0 while reset=0.
   - After release: state OWN_CPU, cnt=0.
6. io_req drops after 3 contended CPU grants, then rises again:
   - Response: counter cleared.
   - IO waits a further 4 CPU grants before its grant.

Source files
------------

// File: rtl/tron_mem_arbiter.sv
// rtl/tron_mem_arbiter.sv - CPU/IO arbiter for the Tron single-port data memory
module tron_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    input  logic                  io_req_i,
    input  logic                  io_we_i,
    input  logic [ADDR_WIDTH-1:0] io_addr_i,
    input  logic [DATA_WIDTH-1:0] io_wdata_i,
    output logic                  io_gnt_o,
    output logic                  io_rvalid_o,
    output logic [DATA_WIDTH-1:0] io_rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  own_io_o
);

    localparam int CW = 4;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic {OWN_CPU = 1'b0, OWN_IO = 1'b1} own_e;

    own_e                  own_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  starve, cpu_gnt, io_gnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  cpu_rvalid_q, io_rvalid_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, io_rdata_q;

    // Grants are gated by rst_ni so nothing reaches the RAM while reset is held.
    assign starve  = (cnt_q == MAX_CNT) && io_req_i;
    assign cpu_gnt = rst_ni && cpu_req_i && !starve;
    assign io_gnt  = rst_ni && io_req_i && (!cpu_req_i || starve);

    assign cpu_gnt_o = cpu_gnt;
    assign io_gnt_o  = io_gnt;
    assign own_io_o  = (own_q == OWN_IO);

    always_comb begin
        cnt_d = cnt_q;
        if (cpu_gnt && io_req_i) begin
            cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CW'(1);
        end else if (io_gnt || !io_req_i) begin
            cnt_d = '0;
        end
    end

    // Idle cycles replay the last address/data so the RAM inputs stay quiet.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (cpu_gnt) begin
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end else if (io_gnt) begin
            mem_we_o    = io_we_i;
            mem_addr_o  = io_addr_i;
            mem_wdata_o = io_wdata_i;
        end
    end

    // The RAM answers one cycle after the address, so rdata passes through while
    // the tag is valid and is captured to hold until that requester's next read.
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign io_rvalid_o  = io_rvalid_q;
    assign cpu_rdata_o  = cpu_rvalid_q ? mem_rdata_i : cpu_rdata_q;
    assign io_rdata_o   = io_rvalid_q ? mem_rdata_i : io_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            own_q        <= OWN_CPU;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            io_rvalid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            io_rdata_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            addr_q       <= mem_addr_o;
            wdata_q      <= mem_wdata_o;
            cpu_rvalid_q <= cpu_gnt && !cpu_we_i;
            io_rvalid_q  <= io_gnt && !io_we_i;
            if (cpu_gnt) begin
                own_q <= OWN_CPU;
            end else if (io_gnt) begin
                own_q <= OWN_IO;
            end
            if (cpu_rvalid_q) begin
                cpu_rdata_q <= mem_rdata_i;
            end
            if (io_rvalid_q) begin
                io_rdata_q <= mem_rdata_i;
            end
        end
    end

endmodule
